// File: rtl/watch_pkg.sv
// Shared watch definitions: alarm FSM state encoding, calendar limits and
// default field widths used by the counter chain and its consumers.
package watch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RINGING = 2'd2,
    ST_SNOOZE  = 2'd3
  } state_t;

  localparam int C_HOURS_PER_DAY = 24;
  localparam int C_MIN_PER_HOUR  = 60;

  localparam int C_SEC_BIT  = 6;
  localparam int C_MIN_BIT  = 6;
  localparam int C_HOUR_BIT = 5;

  function automatic logic time_valid(input int hh, input int mm);
    return (hh < C_HOURS_PER_DAY) && (mm < C_MIN_PER_HOUR);
  endfunction

endpackage

// File: rtl/watch_sec_tick_det.sv
// Second-tick detector: flags any change of the seconds field while the
// watch is running. The delayed copy tracks i_sec even when stopped.
module watch_sec_tick_det #(
  parameter int P_SEC_BIT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run_en,
  input  logic [P_SEC_BIT-1:0] i_sec,
  output logic                 o_tick
);

  logic [P_SEC_BIT-1:0] sec_d_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_d_reg <= '0;
    end else begin
      sec_d_reg <= i_sec;
    end
  end

  assign o_tick = i_run_en & (i_sec != sec_d_reg);

endmodule

// File: rtl/watch_alarm.sv
// Alarm controller: compares the running time against a programmed hh:mm,
// rings at hh:mm:00, and handles stop, limited snooze and ring timeout.
module watch_alarm
  import watch_pkg::*;
#(
  parameter int P_SEC_BIT    = C_SEC_BIT,
  parameter int P_MIN_BIT    = C_MIN_BIT,
  parameter int P_HOUR_BIT   = C_HOUR_BIT,
  parameter int P_RING_SEC   = 60,
  parameter int P_SNOOZE_SEC = 300,
  parameter int P_SNOOZE_BIT = 9,
  parameter int P_MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_run_en,
  input  logic [P_SEC_BIT-1:0]  i_sec,
  input  logic [P_MIN_BIT-1:0]  i_min,
  input  logic [P_HOUR_BIT-1:0] i_hour,
  input  logic                  i_alarm_en,
  input  logic                  i_set,
  input  logic [P_MIN_BIT-1:0]  i_set_min,
  input  logic [P_HOUR_BIT-1:0] i_set_hour,
  input  logic                  i_stop,
  input  logic                  i_snooze,
  output logic                  o_ring,
  output logic [1:0]            o_state,
  output logic [P_MIN_BIT-1:0]  o_alarm_min,
  output logic [P_HOUR_BIT-1:0] o_alarm_hour,
  output logic [1:0]            o_snooze_cnt,
  output logic                  o_missed,
  output logic                  o_set_err
);

  localparam int RING_BIT = (P_RING_SEC > 1) ? $clog2(P_RING_SEC) : 1;

  state_t                  state_reg;
  logic [RING_BIT-1:0]     ring_cnt_reg;
  logic [P_SNOOZE_BIT-1:0] snz_cnt_reg;
  logic [P_MIN_BIT-1:0]    alarm_min_reg;
  logic [P_HOUR_BIT-1:0]   alarm_hour_reg;
  logic [1:0]              snooze_cnt_reg;
  logic                    missed_reg;
  logic                    set_err_reg;

  logic sec_tick;
  logic match;
  logic set_ok;

  watch_sec_tick_det #(
    .P_SEC_BIT (P_SEC_BIT)
  ) u_sec_tick_det (
    .clk      (clk),
    .reset    (reset),
    .i_run_en (i_run_en),
    .i_sec    (i_sec),
    .o_tick   (sec_tick)
  );

  assign match  = sec_tick & (i_sec == '0) & (i_min == alarm_min_reg) & (i_hour == alarm_hour_reg);
  assign set_ok = time_valid(int'(i_set_hour), int'(i_set_min));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      ring_cnt_reg   <= '0;
      snz_cnt_reg    <= '0;
      alarm_min_reg  <= '0;
      alarm_hour_reg <= '0;
      snooze_cnt_reg <= '0;
      missed_reg     <= 1'b0;
      set_err_reg    <= 1'b0;
    end else begin
      // Programming the alarm registers is allowed even while disabled.
      set_err_reg <= i_set & ~set_ok;
      if (i_set && set_ok) begin
        alarm_min_reg  <= i_set_min;
        alarm_hour_reg <= i_set_hour;
        missed_reg     <= 1'b0;
        snooze_cnt_reg <= '0;
      end

      if (!i_alarm_en) begin
        state_reg      <= ST_IDLE;
        ring_cnt_reg   <= '0;
        snz_cnt_reg    <= '0;
        snooze_cnt_reg <= '0;
      end else if (i_set && set_ok) begin
        // A valid set re-arms and swallows any match in the same cycle.
        state_reg <= ST_ARMED;
      end else if (i_stop) begin
        missed_reg <= 1'b0;
        state_reg  <= ST_ARMED;
      end else begin
        case (state_reg)
          ST_IDLE: state_reg <= ST_ARMED;
          ST_ARMED: begin
            if (match) begin
              state_reg      <= ST_RINGING;
              ring_cnt_reg   <= '0;
              snooze_cnt_reg <= '0;
            end
          end
          ST_RINGING: begin
            if (i_snooze && (snooze_cnt_reg < 2'(P_MAX_SNOOZE))) begin
              state_reg      <= ST_SNOOZE;
              snz_cnt_reg    <= P_SNOOZE_BIT'(P_SNOOZE_SEC);
              snooze_cnt_reg <= snooze_cnt_reg + 2'd1;
            end else if (sec_tick) begin
              if (ring_cnt_reg == RING_BIT'(P_RING_SEC - 1)) begin
                state_reg  <= ST_ARMED;
                missed_reg <= 1'b1;
              end else begin
                ring_cnt_reg <= ring_cnt_reg + 1'b1;
              end
            end
          end
          ST_SNOOZE: begin
            if (sec_tick) begin
              if (snz_cnt_reg == P_SNOOZE_BIT'(1)) begin
                state_reg    <= ST_RINGING;
                ring_cnt_reg <= '0;
              end else begin
                snz_cnt_reg <= snz_cnt_reg - 1'b1;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_ring       = (state_reg == ST_RINGING);
  assign o_state      = state_reg;
  assign o_alarm_min  = alarm_min_reg;
  assign o_alarm_hour = alarm_hour_reg;
  assign o_snooze_cnt = snooze_cnt_reg;
  assign o_missed     = missed_reg;
  assign o_set_err    = set_err_reg;

endmodule
